alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one ALU_32bit instance between NREQ requesters (execute stage, branch unit, address-gen).
//  Per-port valid/ready request and response handshakes; round-robin grant.
//  Operands and control are registered into the ALU; Result/Cout/willBranch are captured and returned to the granted port.
//  Sits between the pipeline control units and the single ALU in the KGP-RISC datapath.
// PARAMETERS
//  NREQ   2   number of requesters (2..4)
//  DW     32  operand/result width (fixed to ALU width)
//  CW     7   control word width: {Op[2:0],B_inv,Cin,BranchType[1:0]}
// PORTS
//  clk          in   1          single clock, rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  req_valid    in   NREQ       per-port request valid
//  req_ready    out  NREQ       per-port request accepted this cycle (one-hot or zero)
//  req_a        in   NREQ*DW    operand A, port i at [i*DW +: DW]
//  req_b        in   NREQ*DW    operand B, port i at [i*DW +: DW]
//  req_ctrl     in   NREQ*CW    control word, port i at [i*CW +: CW]
//  resp_valid   out  NREQ       one-hot response valid to owning port
//  resp_ready   in   NREQ       per-port response accept
//  resp_result  out  DW         captured ALU Result (shared bus)
//  resp_cout    out  1          captured ALU Cout
//  resp_branch  out  1          captured ALU willBranch
//  alu_a/alu_b  out  DW         to ALU A/B
//  alu_op       out  3          to ALU Op
//  alu_binv/alu_cin out 1       to ALU B_inv/Cin
//  alu_btype    out  2          to ALU BranchType
//  alu_result   in   DW         from ALU Result
//  alu_cout/alu_branch in 1     from ALU Cout/willBranch
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, rr pointer=0, all req_ready/resp_valid=0,
//   alu_* and resp_* outputs=0. Reset mid-operation abandons the op; no response is issued.
//  FSM: IDLE -> EXEC -> RESP -> (IDLE | EXEC).
//   IDLE: if any req_valid, grant one port (round-robin from pointer), req_ready[g]=1
//    combinationally that cycle; latch a/b/ctrl into operand regs and grant index; go EXEC.
//   EXEC: operand regs drive alu_* for one full cycle; at cycle end capture
//    alu_result/cout/branch into resp regs; go RESP.
//   RESP: resp_valid[g]=1, held stable with data until resp_ready[g]=1.
//    On handshake: if any req_valid, accept a new request the same cycle (back-to-back) and go EXEC;
//    otherwise go IDLE.
//  Latency: accept at edge N -> resp_valid high in cycle N+2. Peak throughput one op per 2 cycles.
//  Round-robin: pointer = (g+1) mod NREQ after each grant; search starts at pointer.
//   Ties between simultaneous valids are resolved by search order only.
//  req_ready is never asserted in EXEC, or in RESP without resp_ready[g].
//  A requester must hold req_valid and its fields stable until req_ready; deasserting
//   req_valid before grant is legal (no grant is issued).
//  resp_ready on a non-owning port is ignored. alu_* hold last operands in IDLE/RESP
//   (no toggling when idle).
//  Widths: no arithmetic inside the block; ctrl is split verbatim into ALU fields.
// STRUCTURE
//  Shared header alu_arb_defs.vh: CW, ctrl field offsets, state codes (IDLE=2'd0, EXEC=2'd1,
//   RESP=2'd2), ALU op codes (AND=3'b000, XOR=3'b001, ADD=3'b010).
//  One sub-module: rr_arbiter (req[NREQ], ptr -> one-hot grant + index), purely combinational.
//  Top: FSM, operand/ctrl regs, grant index reg, pointer reg, response regs.
// TESTING (bench instantiates ALU_32bit behind the arbiter)
//  1. Port0 ADD a=5,b=3, ctrl={010,0,0,00} -> resp_valid[0] two cycles after accept, result=8, cout=0.
//  2. Port1 SUB a=5,b=3, B_inv=1,Cin=1 -> result=2, cout=1; BranchType=00 with a=b=7 -> branch=1.
//  3. Both ports valid every cycle for 8 grants -> grants alternate 0,1,0,1...; no port starved.
//  4. Port0 holds resp_ready=0 for 5 cycles -> resp_valid/result stable, req_ready stays 0 on all ports.
//  5. Back-to-back: resp_ready and port1 req_valid in the same RESP cycle -> port1 accepted that
//     cycle, next response 2 cycles later.
//  6. rst_n low during EXEC -> all outputs 0 immediately; after release no stale response is issued.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter.
// Holds the control-word layout, FSM state encoding, ALU op codes and a
// small helper that turns a grant index into a one-hot port vector.
package alu_share_arbiter_pkg;

  // Control word: {Op[2:0], B_inv, Cin, BranchType[1:0]}
  localparam int CTRL_W    = 7;
  localparam int OP_LSB    = 4;
  localparam int BINV_BIT  = 3;
  localparam int CIN_BIT   = 2;
  localparam int BTYPE_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;

  // One-hot vector for a port index (up to four ports).
  function automatic logic [3:0] idx_onehot(input int idx);
    idx_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at ptr and wrapping around; the first asserted
// request wins.
//   req       in   NREQ  request vector
//   ptr       in   IW    search start position
//   grant     out  NREQ  one-hot grant (zero when no request)
//   grant_idx out  IW    index of the granted port
//   any       out  1     at least one request present
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  int cand_s;

  // Walk the ports in rotated order and pick the first requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand_s    = 0;
    for (int off = 0; off < NREQ; off++) begin
      cand_s = int'(ptr) + off;
      if (cand_s >= NREQ) begin
        cand_s = cand_s - NREQ;
      end else begin
        cand_s = cand_s;
      end
      if (!any && req[cand_s]) begin
        any           = 1'b1;
        grant[cand_s] = 1'b1;
        grant_idx     = IW'(cand_s);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit ALU between NREQ requesters.
// Requests are accepted with a valid/ready handshake and granted
// round-robin; operands are registered into the ALU, the ALU outputs are
// captured one cycle later and held on the shared response bus until the
// owning port accepts them.
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-port request handshake (ready is one-hot)
//   req_a/req_b/req_ctrl    packed per-port operands and control words
//   resp_valid/resp_ready   per-port response handshake (valid is one-hot)
//   resp_result/cout/branch captured ALU outputs
//   alu_*                   registered drive into / results from the ALU
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int CW   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  input  logic [NREQ*CW-1:0] req_ctrl,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [DW-1:0]     resp_result,
  output logic              resp_cout,
  output logic              resp_branch,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_binv,
  output logic              alu_cin,
  output logic [1:0]        alu_btype,
  input  logic [DW-1:0]     alu_result,
  input  logic              alu_cout,
  input  logic              alu_branch
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  state_t          state_r, state_nxt_s;
  logic [IW-1:0]   ptr_r, idx_r, gnt_idx_s, ptr_nxt_s;
  logic [NREQ-1:0] gnt_oh_s, resp_valid_r;
  logic            any_s, accept_s, hs_s;
  logic [DW-1:0]   a_r, b_r, res_r;
  logic [CW-1:0]   ctrl_r;
  logic            cout_r, br_r;
  logic [3:0]      idx_oh_s;
  logic [DW-1:0]   a_arr_s [NREQ];
  logic [DW-1:0]   b_arr_s [NREQ];
  logic [CW-1:0]   ctrl_arr_s [NREQ];

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_r),
    .grant     (gnt_oh_s),
    .grant_idx (gnt_idx_s),
    .any       (any_s)
  );

  // Unpack the per-port buses so the granted port can be selected by index.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr_s[i]    = req_a[i*DW +: DW];
      b_arr_s[i]    = req_b[i*DW +: DW];
      ctrl_arr_s[i] = req_ctrl[i*CW +: CW];
    end
  end

  // Next-state logic; a response handshake can accept a new request in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    hs_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready[idx_r]) begin
          hs_s = 1'b1;
          if (any_s) begin
            accept_s    = 1'b1;
            state_nxt_s = ST_EXEC;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Request ready is combinational on the grant; forced low while reset is held.
  always_comb begin
    if (accept_s && rst_n) begin
      req_ready = gnt_oh_s;
    end else begin
      req_ready = '0;
    end
  end

  // Pointer advances past the granted port, wrapping at NREQ.
  always_comb begin
    if (gnt_idx_s == IW'(NREQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gnt_idx_s + IW'(1);
    end
    idx_oh_s = idx_onehot(int'(idx_r));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand, control, grant index and pointer capture on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      ctrl_r <= '0;
      idx_r  <= '0;
      ptr_r  <= '0;
    end else if (accept_s) begin
      a_r    <= a_arr_s[gnt_idx_s];
      b_r    <= b_arr_s[gnt_idx_s];
      ctrl_r <= ctrl_arr_s[gnt_idx_s];
      idx_r  <= gnt_idx_s;
      ptr_r  <= ptr_nxt_s;
    end
  end

  // Capture ALU outputs at the end of EXEC; response valid drops on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r        <= '0;
      cout_r       <= 1'b0;
      br_r         <= 1'b0;
      resp_valid_r <= '0;
    end else if (state_r == ST_EXEC) begin
      res_r        <= alu_result;
      cout_r       <= alu_cout;
      br_r         <= alu_branch;
      resp_valid_r <= idx_oh_s[NREQ-1:0];
    end else if (hs_s) begin
      resp_valid_r <= '0;
    end
  end

  // Control word is split verbatim into the ALU fields.
  assign alu_a       = a_r;
  assign alu_b       = b_r;
  assign alu_op      = ctrl_r[OP_LSB +: 3];
  assign alu_binv    = ctrl_r[BINV_BIT];
  assign alu_cin     = ctrl_r[CIN_BIT];
  assign alu_btype   = ctrl_r[BTYPE_LSB +: 2];
  assign resp_valid  = resp_valid_r;
  assign resp_result = res_r;
  assign resp_cout   = cout_r;
  assign resp_branch = br_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int CW   = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ*DW-1:0] req_a, req_b;
  logic [NREQ*CW-1:0] req_ctrl;
  logic [DW-1:0]     resp_result, alu_a, alu_b, alu_result;
  logic              resp_cout, resp_branch, alu_binv, alu_cin, alu_cout, alu_branch;
  logic [2:0]        alu_op;
  logic [1:0]        alu_btype;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_cout(resp_cout), .resp_branch(resp_branch),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_binv(alu_binv), .alu_cin(alu_cin), .alu_btype(alu_btype),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_branch(alu_branch)
  );

  // Behavioural ALU_32bit behind the arbiter
  logic [DW-1:0] bx;
  logic [DW:0]   sum;
  always_comb begin
    bx  = alu_binv ? ~alu_b : alu_b;
    sum = {1'b0, alu_a} + {1'b0, bx} + {32'd0, alu_cin};
    case (alu_op)
      3'b000:  alu_result = alu_a & bx;
      3'b001:  alu_result = alu_a ^ bx;
      3'b010:  alu_result = sum[DW-1:0];
      default: alu_result = 32'd0;
    endcase
    alu_cout = (alu_op == 3'b010) ? sum[DW] : 1'b0;
    case (alu_btype)
      2'b00:   alu_branch = (alu_result == 32'd0);
      2'b01:   alu_branch = (alu_result != 32'd0);
      2'b10:   alu_branch = alu_result[DW-1];
      default: alu_branch = 1'b0;
    endcase
  end

  typedef struct {
    int          port;
    logic [31:0] result;
    logic        cout;
    logic        branch;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int port, input logic [31:0] r, input logic c, input logic b);
    exp_t e;
    e.port = port; e.result = r; e.cout = c; e.branch = b;
    sb.push_back(e);
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [6:0] ctrl);
    req_a[p*DW +: DW]    = a;
    req_b[p*DW +: DW]    = b;
    req_ctrl[p*CW +: CW] = ctrl;
  endtask

  // Drive a single-port request, check it is granted this cycle, release after the edge.
  task automatic issue(input string tag, input int p, input logic [31:0] a,
                       input logic [31:0] b, input logic [6:0] ctrl);
    logic [1:0] oh;
    oh = 2'b01 << p;
    set_port(p, a, b, ctrl);
    req_valid[p] = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, {62'd0, req_ready}, {62'd0, oh});
    tick();
    req_valid[p] = 1'b0;
  endtask

  // Called at a negedge while a response is expected: compare and handshake it.
  task automatic take_resp(input string tag);
    exp_t e;
    logic [1:0] oh;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, {62'd0, resp_valid}, 64'd0);
    end else begin
      e  = sb.pop_front();
      oh = 2'b01 << e.port;
      check({tag, "_valid"},  {62'd0, resp_valid}, {62'd0, oh});
      check({tag, "_result"}, {32'd0, resp_result}, {32'd0, e.result});
      check({tag, "_cout"},   {63'd0, resp_cout}, {63'd0, e.cout});
      check({tag, "_branch"}, {63'd0, resp_branch}, {63'd0, e.branch});
      resp_ready[e.port] = 1'b1;
      tick();
      resp_ready = 2'b00;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int p;
    int n;
    logic [31:0] hold_res;
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
    req_a = '0; req_b = '0; req_ctrl = '0;
    tick(); tick();
    // Reset state
    @(negedge clk);
    check("rst_req_ready", {62'd0, req_ready}, 64'd0);
    check("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
    check("rst_alu_a", {32'd0, alu_a}, 64'd0);
    check("rst_resp_result", {32'd0, resp_result}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1. Port0 ADD 5+3, response two cycles after accept
    push(0, 32'd8, 1'b0, 1'b0);
    issue("t1", 0, 32'd5, 32'd3, 7'b010_0_0_00);
    @(negedge clk);
    check("t1_exec_no_resp", {62'd0, resp_valid}, 64'd0);
    check("t1_alu_a", {32'd0, alu_a}, 64'd5);
    check("t1_alu_op", {61'd0, alu_op}, 64'd2);
    tick();
    @(negedge clk);
    take_resp("t1");

    // 2. Port1 SUB 5-3, then SUB 7-7 with BranchType 00
    push(1, 32'd2, 1'b1, 1'b0);
    issue("t2a", 1, 32'd5, 32'd3, 7'b010_1_1_00);
    @(negedge clk);
    tick();
    @(negedge clk);
    take_resp("t2a");
    push(1, 32'd0, 1'b1, 1'b1);
    issue("t2b", 1, 32'd7, 32'd7, 7'b010_1_1_00);
    @(negedge clk);
    tick();
    @(negedge clk);
    take_resp("t2b");

    // 3. Both ports valid continuously: grants alternate starting at port0
    set_port(0, 32'd10, 32'd1, 7'b010_0_0_00);
    set_port(1, 32'd20, 32'd2, 7'b010_0_0_00);
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    g = 0;
    n = 0;
    while (n < 40 && (g < 8 || sb.size() > 0)) begin
      @(negedge clk);
      if (resp_valid != 2'b00) begin
        exp_t e;
        logic [1:0] oh;
        if (sb.size() == 0) begin
          check("t3_spurious_resp", {62'd0, resp_valid}, 64'd0);
        end else begin
          e  = sb.pop_front();
          oh = 2'b01 << e.port;
          check("t3_resp_valid", {62'd0, resp_valid}, {62'd0, oh});
          check("t3_resp_result", {32'd0, resp_result}, {32'd0, e.result});
        end
      end
      p = -1;
      if (req_ready != 2'b00) begin
        p = req_ready[1] ? 1 : 0;
        check("t3_grant_order", 64'(p), 64'(g % 2));
        push(p, req_a[p*DW +: DW] + req_b[p*DW +: DW], 1'b0, 1'b0);
        g++;
      end
      tick();
      if (p >= 0) begin
        req_a[p*DW +: DW] = req_a[p*DW +: DW] + 32'd3;
      end
      if (g >= 8) begin
        req_valid = 2'b00;
      end
      n++;
    end
    check("t3_grant_count", 64'(g), 64'd8);
    check("t3_sb_drained", 64'(sb.size()), 64'd0);
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    tick();

    // 4. Port0 stalls its response for 5 cycles while port1 waits
    push(0, 32'd123, 1'b0, 1'b0);
    issue("t4", 0, 32'd100, 32'd23, 7'b010_0_0_00);
    set_port(1, 32'd9, 32'd4, 7'b010_1_1_00);
    req_valid[1] = 1'b1;
    @(negedge clk);
    check("t4_exec_ready", {62'd0, req_ready}, 64'd0);
    tick();
    hold_res = 32'd123;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_hold_valid", {62'd0, resp_valid}, 64'd1);
      check("t4_hold_result", {32'd0, resp_result}, {32'd0, hold_res});
      check("t4_hold_ready", {62'd0, req_ready}, 64'd0);
      tick();
    end

    // 5. Handshake and port1 request in the same RESP cycle
    @(negedge clk);
    begin
      exp_t e;
      e = sb.pop_front();
      check("t5_prev_valid", {62'd0, resp_valid}, 64'd1);
      check("t5_prev_result", {32'd0, resp_result}, {32'd0, e.result});
    end
    resp_ready[0] = 1'b1;
    #1;
    check("t5_b2b_ready", {62'd0, req_ready}, 64'd2);
    push(1, 32'd5, 1'b1, 1'b0);
    tick();
    resp_ready = 2'b00;
    req_valid  = 2'b00;
    @(negedge clk);
    check("t5_exec_no_resp", {62'd0, resp_valid}, 64'd0);
    tick();
    @(negedge clk);
    take_resp("t5");

    // 6. Reset during EXEC abandons the operation
    issue("t6", 0, 32'h0000_f0f0, 32'h0000_ff00, 7'b000_0_0_00);
    req_valid[1] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req_ready", {62'd0, req_ready}, 64'd0);
    check("t6_rst_resp_valid", {62'd0, resp_valid}, 64'd0);
    check("t6_rst_alu_a", {32'd0, alu_a}, 64'd0);
    check("t6_rst_alu_b", {32'd0, alu_b}, 64'd0);
    tick();
    req_valid = 2'b00;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_no_stale_resp", {62'd0, resp_valid}, 64'd0);
      tick();
    end
    // Pointer restarts at port0 after reset
    set_port(0, 32'd1, 32'd1, 7'b010_0_0_00);
    set_port(1, 32'd2, 32'd2, 7'b010_0_0_00);
    req_valid = 2'b11;
    @(negedge clk);
    check("t6_post_rst_grant", {62'd0, req_ready}, 64'd1);
    push(0, 32'd2, 1'b0, 1'b0);
    tick();
    req_valid = 2'b00;
    n = 0;
    @(negedge clk);
    while (resp_valid == 2'b00 && n < 10) begin
      tick();
      @(negedge clk);
      n++;
    end
    take_resp("t6_post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
